// File: rtl/bcd_updown_cnt_disp_if.sv
// Control/status bundle between board logic and the BCD counter with 7-segment scan.
// master drives the controls and observes the display; slave is the counter itself.
interface bcd_updown_cnt_disp_if #(
    parameter int unsigned NUM_DIGITS = 2
);
    logic                      en;
    logic                      up_dn;
    logic                      wrap_mode;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   load_val;
    logic [4*NUM_DIGITS-1:0]   count;
    logic                      tc;
    logic [6:0]                seg;
    logic [NUM_DIGITS-1:0]     digit_sel;

    modport master (
        output en, up_dn, wrap_mode, load, load_val,
        input  count, tc, seg, digit_sel
    );

    modport slave (
        input  en, up_dn, wrap_mode, load, load_val,
        output count, tc, seg, digit_sel
    );
endinterface

// File: rtl/bcd_updown_cnt_disp.sv
// Multi-digit BCD up/down counter with parallel load, wrap/saturate boundary handling,
// terminal-count pulse and a time-multiplexed active-low 7-segment scan driver.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant
// non-zero digit (digit 0 is never blanked).
module bcd_updown_cnt_disp #(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned SCAN_DIV   = 1000
) (
    input logic                  clk,
    input logic                  rst_n,
    bcd_updown_cnt_disp_if.slave bus
);
    localparam int unsigned CntW = 4 * NUM_DIGITS;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] AllNine = {NUM_DIGITS{4'h9}};

    typedef enum logic [1:0] {StRst, StRun, StHold} state_e;

    state_e            state_q;
    logic [CntW-1:0]   count_q;
    logic              tc_q;
    logic [IdxW-1:0]   scan_idx_q;
    logic [PreW-1:0]   presc_q;

    logic [CntW-1:0]   step_val;
    logic [CntW-1:0]   load_clean;
    logic              all_nine;
    logic              all_zero;
    logic              carry;
    logic [3:0]        dig;
    logic              at_bound;
    logic              away;
    logic [3:0]        sel_digit;
    logic [6:0]        seg_raw;
    logic [6:0]        seg_out;

    // One BCD ripple step in the requested direction; carry/borrow ripples from the LSD.
    always_comb begin
        step_val = '0;
        carry    = 1'b1;
        all_nine = 1'b1;
        all_zero = 1'b1;
        dig      = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (dig != 4'd9) all_nine = 1'b0;
            if (dig != 4'd0) all_zero = 1'b0;
            if (!carry) begin
                step_val[4*i +: 4] = dig;
            end else if (bus.up_dn) begin
                if (dig == 4'd9) begin
                    step_val[4*i +: 4] = 4'd0;
                end else begin
                    step_val[4*i +: 4] = dig + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                if (dig == 4'd0) begin
                    step_val[4*i +: 4] = 4'd9;
                end else begin
                    step_val[4*i +: 4] = dig - 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // Clamp out-of-range load digits to 9 so no A..F value ever enters the count.
    always_comb begin
        load_clean = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_clean[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd9
                                                                   : bus.load_val[4*i +: 4];
        end
    end

    assign at_bound = bus.up_dn ? all_nine : all_zero;
    // In hold the count sits on a boundary; stepping away means heading to the other end.
    assign away     = bus.up_dn ? all_zero : all_nine;

    // Counter FSM: load beats enable; the ripple step already wraps, so wrap reuses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRst;
            count_q <= AllNine;
            tc_q    <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (bus.load) begin
                count_q <= load_clean;
                state_q <= StRun;
            end else begin
                case (state_q)
                    StRst: state_q <= StRun;
                    StRun: begin
                        if (bus.en) begin
                            if (at_bound) begin
                                tc_q <= 1'b1;
                                if (bus.wrap_mode) count_q <= step_val;
                                else               state_q <= StHold;
                            end else begin
                                count_q <= step_val;
                            end
                        end
                    end
                    StHold: begin
                        if (bus.en && away) begin
                            count_q <= step_val;
                            state_q <= StRun;
                        end
                    end
                    default: state_q <= StRun;
                endcase
            end
        end
    end

    // Scan prescaler and digit index, free-running regardless of counter activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            scan_idx_q <= '0;
        end else if (presc_q == PreW'(SCAN_DIV - 1)) begin
            presc_q <= '0;
            if (scan_idx_q == IdxW'(NUM_DIGITS - 1)) scan_idx_q <= '0;
            else                                      scan_idx_q <= scan_idx_q + 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Select the scanned digit and decode it to active-low segments {g,f,e,d,c,b,a}.
    always_comb begin
        sel_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_q == IdxW'(i)) sel_digit = count_q[4*i +: 4];
        end
        case (sel_digit)
            4'd0:    seg_raw = 7'b1000000;
            4'd1:    seg_raw = 7'b1111001;
            4'd2:    seg_raw = 7'b0100100;
            4'd3:    seg_raw = 7'b0110000;
            4'd4:    seg_raw = 7'b0011001;
            4'd5:    seg_raw = 7'b0010010;
            4'd6:    seg_raw = 7'b0000010;
            4'd7:    seg_raw = 7'b1111000;
            4'd8:    seg_raw = 7'b0000000;
            4'd9:    seg_raw = 7'b0010000;
            default: seg_raw = 7'b1111111;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;

    // Blank a zero digit when every digit above it is zero too; digit 0 always shows.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i > int'(scan_idx_q)) && (count_q[4*i +: 4] != 4'd0)) upper_zero = 1'b0;
        end
        if ((scan_idx_q != '0) && (sel_digit == 4'd0) && upper_zero) seg_out = 7'b1111111;
        else                                                         seg_out = seg_raw;
    end
`else
    assign seg_out = seg_raw;
`endif

    assign bus.count     = count_q;
    assign bus.tc        = tc_q;
    assign bus.seg       = seg_out;
    assign bus.digit_sel = ~(NUM_DIGITS'(1) << scan_idx_q);
endmodule

// File: tb/tb_bcd_updown_cnt_disp.sv
// Directed bench for bcd_updown_cnt_disp (NUM_DIGITS=2, SCAN_DIV=4): vector table for
// single-step behaviour plus hand-written reset, wrap-sequence and scan sequences.
// Honours LEADING_ZERO_BLANK_EN when the build defines it.
module tb_bcd_updown_cnt_disp;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_updown_cnt_disp_if #(.NUM_DIGITS(2)) bus ();

    bcd_updown_cnt_disp #(
        .NUM_DIGITS(2),
        .SCAN_DIV  (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total  = 0;
    int bad    = 0;
    int scan_k = 0;

    typedef struct {
        logic       load;
        logic [7:0] load_val;
        logic       en;
        logic       up_dn;
        logic       wrap_mode;
        logic [7:0] exp_count;
        logic       exp_tc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ld, input logic [7:0] lv, input logic e, input logic u,
                       input logic w, input logic [7:0] ec, input logic et);
        vec_t v;
        v.load = ld; v.load_val = lv; v.en = e; v.up_dn = u; v.wrap_mode = w;
        v.exp_count = ec; v.exp_tc = et;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        scan_k++;
    endtask

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Digit-validity watch: no nibble of count may ever exceed 9.
    always @(negedge clk) begin
        logic [7:0] c;
        c = bus.count;
        total++;
        if (c[3:0] > 4'd9 || c[7:4] > 4'd9) begin
            bad++;
            $display("FAIL bcd_digit: got %0h, expected digits 0..9", c);
        end
    end

    // Scan model: prescaler 0..3, index toggles every 4 edges since reset release.
    task automatic check_scan(input string tag, input logic [7:0] val, input int n);
        int         idx;
        logic [3:0] d;
        logic [6:0] es;
        for (int k = 0; k < n; k++) begin
            step();
            idx = (scan_k / 4) % 2;
            d   = (idx == 1) ? val[7:4] : val[3:0];
            es  = seg_code(d);
`ifdef LEADING_ZERO_BLANK_EN
            if (idx == 1 && d == 4'd0) es = 7'b1111111;
`endif
            chk({tag, " digit_sel"}, 32'(bus.digit_sel), (idx == 1) ? 32'h1 : 32'h2);
            chk({tag, " seg"}, 32'(bus.seg), 32'(es));
        end
    endtask

    initial begin
        bus.en = 1'b1; bus.up_dn = 1'b0; bus.wrap_mode = 1'b1;
        bus.load = 1'b0; bus.load_val = 8'h00;

        // Reset state, held across a clock edge.
        #12;
        chk("rst count", 32'(bus.count), 32'h99);
        chk("rst tc", 32'(bus.tc), 32'h0);
        chk("rst digit_sel", 32'(bus.digit_sel), 32'h2);
        @(negedge clk);
        rst_n  = 1'b1;
        scan_k = 0;

        // Down-count with wrap: S_RST hold cycle, then 98..00, then 99 with a one-cycle tc.
        step();
        chk("srst hold count", 32'(bus.count), 32'h99);
        chk("srst hold tc", 32'(bus.tc), 32'h0);
        for (int v = 98; v >= 0; v--) begin
            step();
            chk("down count", 32'(bus.count), 32'(bcd2(v)));
            chk("down tc", 32'(bus.tc), 32'h0);
        end
        step();
        chk("wrap99 count", 32'(bus.count), 32'h99);
        chk("wrap99 tc", 32'(bus.tc), 32'h1);
        step();
        chk("after wrap count", 32'(bus.count), 32'h98);
        chk("after wrap tc", 32'(bus.tc), 32'h0);

        //   load  val    en    up    wrap  exp    tc
        add(1'b1, 8'h09, 1'b0, 1'b1, 1'b1, 8'h09, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0); // carry
        add(1'b1, 8'h98, 1'b1, 1'b1, 1'b1, 8'h98, 1'b0); // load beats en
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1); // up wrap
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0); // en=0 holds
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0); // direction change immediate
        add(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1); // saturate -> hold
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0); // away step leaves hold
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h02, 1'b0);
        add(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h95, 1'b0); // sanitised load
        add(1'b1, 8'h98, 1'b0, 1'b1, 1'b0, 8'h98, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h99, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h99, 1'b1); // saturate at top
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h99, 1'b0);
        add(1'b1, 8'h45, 1'b1, 1'b1, 1'b0, 8'h45, 1'b0); // load during hold
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h46, 1'b0);
        add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h99, 1'b0); // no tc on load at boundary
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h99, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h98, 1'b0); // away downward from 99

        for (int i = 0; i < vecs.size(); i++) begin
            bus.load = vecs[i].load; bus.load_val = vecs[i].load_val;
            bus.en = vecs[i].en; bus.up_dn = vecs[i].up_dn; bus.wrap_mode = vecs[i].wrap_mode;
            step();
            chk($sformatf("vec%0d count", i), 32'(bus.count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d tc", i), 32'(bus.tc), 32'(vecs[i].exp_tc));
        end

        // Asynchronous reset mid-cycle while counting at 37.
        bus.load = 1'b1; bus.load_val = 8'h36; bus.en = 1'b0; bus.up_dn = 1'b1;
        bus.wrap_mode = 1'b1;
        step();
        bus.load = 1'b0; bus.en = 1'b1;
        step();
        chk("pre-reset count", 32'(bus.count), 32'h37);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst count", 32'(bus.count), 32'h99);
        chk("async rst digit_sel", 32'(bus.digit_sel), 32'h2);
        chk("async rst tc", 32'(bus.tc), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("re-srst count", 32'(bus.count), 32'h99);
        chk("re-srst tc", 32'(bus.tc), 32'h0);
        step();
        chk("re-srst wrap count", 32'(bus.count), 32'h00);
        chk("re-srst wrap tc", 32'(bus.tc), 32'h1);

        // Scan timing from a fresh reset; 42 is loaded in the S_RST cycle.
        @(negedge clk);
        rst_n = 1'b0;
        bus.load = 1'b1; bus.load_val = 8'h42; bus.en = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        scan_k = 0;
        step();
        bus.load = 1'b0;
        chk("scan load42 count", 32'(bus.count), 32'h42);
        chk("scan first digit_sel", 32'(bus.digit_sel), 32'h2);
        chk("scan first seg", 32'(bus.seg), 32'(seg_code(4'd2)));
        check_scan("scan42", 8'h42, 11);

        bus.load = 1'b1; bus.load_val = 8'h05;
        step();
        bus.load = 1'b0;
        check_scan("scan05", 8'h05, 8);

        bus.load = 1'b1; bus.load_val = 8'h00;
        step();
        bus.load = 1'b0;
        check_scan("scan00", 8'h00, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
